// File: rtl/fifo_lsram_pkg.sv
// Shared widths, types and default thresholds for the LSRAM-backed FIFO controller.
package fifo_lsram_pkg;

  localparam int FIFO_DWIDTH        = 32;
  localparam int FIFO_AWIDTH        = 9;
  localparam int FIFO_DEPTH         = 1 << FIFO_AWIDTH;
  localparam int FIFO_AFULL_THRESH  = 480;
  localparam int FIFO_AEMPTY_THRESH = 32;

  // One extra bit over the RAM address so full and empty stay distinguishable.
  typedef logic [FIFO_AWIDTH:0]   ptr_t;
  typedef logic [FIFO_AWIDTH:0]   cnt_t;
  typedef logic [FIFO_DWIDTH-1:0] data_t;

endpackage

// File: rtl/fifo_lsram_ptr.sv
// Wrapping FIFO pointer: AWIDTH address bits plus a wrap bit, with async and sync clear.
module fifo_lsram_ptr
  import fifo_lsram_pkg::*;
#(
  parameter int AWIDTH = FIFO_AWIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            srst,
  input  logic            inc,
  output logic [AWIDTH:0] ptr
);

  localparam logic [AWIDTH:0] PTR_ZERO = {(AWIDTH+1){1'b0}};
  localparam logic [AWIDTH:0] PTR_ONE  = {{AWIDTH{1'b0}}, 1'b1};

  logic [AWIDTH:0] ptr_r;

  // Pointer register; natural binary carry takes 511 -> 0 and flips the wrap bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= PTR_ZERO;
    end else if (srst) begin
      ptr_r <= PTR_ZERO;
    end else if (inc) begin
      ptr_r <= ptr_r + PTR_ONE;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/fifo_lsram_ctrl.sv
// FIFO controller for the 512x32 two-port LSRAM wrapper (write port B, read port A).
// Define FIFO_ALMOST_FLAGS_EN to build the registered AFULL/AEMPTY threshold flags.
module fifo_lsram_ctrl
  import fifo_lsram_pkg::*;
#(
  parameter int DWIDTH = FIFO_DWIDTH,
  parameter int AWIDTH = FIFO_AWIDTH
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  parameter int AFULL_THRESH  = FIFO_AFULL_THRESH,
  parameter int AEMPTY_THRESH = FIFO_AEMPTY_THRESH
`endif
) (
  input  logic              CLK,
  input  logic              ARST_N,
  input  logic              FLUSH,
  input  logic              WE,
  input  logic [DWIDTH-1:0] WDATA,
  input  logic              RE,
  output logic [DWIDTH-1:0] RDATA,
  output logic              RVALID,
  output logic              FULL,
  output logic              EMPTY,
  output logic [AWIDTH:0]   COUNT,
  output logic              OVERFLOW,
  output logic              UNDERFLOW,
`ifdef FIFO_ALMOST_FLAGS_EN
  output logic              AFULL,
  output logic              AEMPTY,
`endif
  output logic [DWIDTH-1:0] RAM_WD,
  output logic [AWIDTH-1:0] RAM_WADDR,
  output logic              RAM_WEN,
  output logic [AWIDTH-1:0] RAM_RADDR,
  output logic              RAM_REN,
  output logic              RAM_RD_EN,
  output logic              RAM_RD_SRST_N,
  input  logic [DWIDTH-1:0] RAM_RD
);

  localparam logic [AWIDTH:0] CNT_ZERO  = {(AWIDTH+1){1'b0}};
  localparam logic [AWIDTH:0] CNT_ONE   = {{AWIDTH{1'b0}}, 1'b1};
  localparam logic [AWIDTH:0] CNT_DEPTH = {1'b1, {AWIDTH{1'b0}}};
`ifdef FIFO_ALMOST_FLAGS_EN
  localparam logic [AWIDTH:0] CNT_AFULL  = (AWIDTH+1)'(AFULL_THRESH);
  localparam logic [AWIDTH:0] CNT_AEMPTY = (AWIDTH+1)'(AEMPTY_THRESH);
`endif

  logic            push_ok_s;
  logic            pop_ok_s;
  logic [AWIDTH:0] wptr_s;
  logic [AWIDTH:0] rptr_s;
  logic [AWIDTH:0] count_nxt_s;
  logic [AWIDTH:0] count_r;
  logic            full_r;
  logic            empty_r;
  logic [1:0]      vld_r;
  logic            ovf_r;
  logic            udf_r;
  logic [1:0]      ptr_msb_unused_s;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic            afull_r;
  logic            aempty_r;
`endif

  // Requests are ignored while in reset or during a flush cycle.
  assign push_ok_s = WE & ~full_r  & ~FLUSH & ARST_N;
  assign pop_ok_s  = RE & ~empty_r & ~FLUSH & ARST_N;

  fifo_lsram_ptr #(.AWIDTH(AWIDTH)) u_wptr (
    .clk   (CLK),
    .rst_n (ARST_N),
    .srst  (FLUSH),
    .inc   (push_ok_s),
    .ptr   (wptr_s)
  );

  fifo_lsram_ptr #(.AWIDTH(AWIDTH)) u_rptr (
    .clk   (CLK),
    .rst_n (ARST_N),
    .srst  (FLUSH),
    .inc   (pop_ok_s),
    .ptr   (rptr_s)
  );

  // Wrap bits are kept on the pointers for debug visibility; occupancy comes from COUNT.
  assign ptr_msb_unused_s = {wptr_s[AWIDTH], rptr_s[AWIDTH]};

  // Next occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    if (FLUSH) begin
      count_nxt_s = CNT_ZERO;
    end else if (push_ok_s && !pop_ok_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (!push_ok_s && pop_ok_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Occupancy, status flags and reject pulses, all derived from the next-state count.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      count_r  <= CNT_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
`ifdef FIFO_ALMOST_FLAGS_EN
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
`endif
    end else begin
      count_r  <= count_nxt_s;
      full_r   <= (count_nxt_s == CNT_DEPTH);
      empty_r  <= (count_nxt_s == CNT_ZERO);
      ovf_r    <= WE & full_r  & ~FLUSH;
      udf_r    <= RE & empty_r & ~FLUSH;
`ifdef FIFO_ALMOST_FLAGS_EN
      afull_r  <= (count_nxt_s >= CNT_AFULL);
      aempty_r <= (count_nxt_s <= CNT_AEMPTY);
`endif
    end
  end

  // Two-stage valid pipe matching the array latch plus the RAM output register.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      vld_r <= 2'b00;
    end else if (FLUSH) begin
      vld_r <= 2'b00;
    end else begin
      vld_r <= {vld_r[0], pop_ok_s};
    end
  end

  assign RAM_WEN       = push_ok_s;
  assign RAM_WADDR     = wptr_s[AWIDTH-1:0];
  assign RAM_WD        = WDATA;
  assign RAM_REN       = pop_ok_s;
  assign RAM_RADDR     = rptr_s[AWIDTH-1:0];
  assign RAM_RD_EN     = 1'b1;
  assign RAM_RD_SRST_N = ~(FLUSH & ARST_N);

  assign RDATA     = RAM_RD;
  assign RVALID    = vld_r[1];
  assign COUNT     = count_r;
  assign FULL      = full_r;
  assign EMPTY     = empty_r;
  assign OVERFLOW  = ovf_r;
  assign UNDERFLOW = udf_r;
`ifdef FIFO_ALMOST_FLAGS_EN
  assign AFULL     = afull_r;
  assign AEMPTY    = aempty_r;
`endif

endmodule

// File: tb/tb_fifo_lsram_ctrl.sv
// Scoreboard bench for fifo_lsram_ctrl with a behavioural LSRAM and a queue-based FIFO model.
module tb_fifo_lsram_ctrl;

  logic        CLK = 1'b0;
  logic        ARST_N, FLUSH, WE, RE;
  logic [31:0] WDATA, RDATA, RAM_WD, RAM_RD;
  logic        RVALID, FULL, EMPTY, OVERFLOW, UNDERFLOW;
  logic [9:0]  COUNT;
  logic [8:0]  RAM_WADDR, RAM_RADDR;
  logic        RAM_WEN, RAM_REN, RAM_RD_EN, RAM_RD_SRST_N;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic        AFULL, AEMPTY;
`endif

  fifo_lsram_ctrl dut (
    .CLK(CLK), .ARST_N(ARST_N), .FLUSH(FLUSH), .WE(WE), .WDATA(WDATA), .RE(RE),
    .RDATA(RDATA), .RVALID(RVALID), .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW),
`ifdef FIFO_ALMOST_FLAGS_EN
    .AFULL(AFULL), .AEMPTY(AEMPTY),
`endif
    .RAM_WD(RAM_WD), .RAM_WADDR(RAM_WADDR), .RAM_WEN(RAM_WEN),
    .RAM_RADDR(RAM_RADDR), .RAM_REN(RAM_REN), .RAM_RD_EN(RAM_RD_EN),
    .RAM_RD_SRST_N(RAM_RD_SRST_N), .RAM_RD(RAM_RD)
  );

  always #5 CLK = ~CLK;

  // Behavioural LSRAM: array latch on edge 1, output register on edge 2.
  logic [31:0] mem [512];
  logic [31:0] lat_q, out_q;
  always @(posedge CLK) begin
    if (RAM_WEN) mem[RAM_WADDR] <= RAM_WD;
    if (RAM_REN) lat_q <= mem[RAM_RADDR];
    if (!RAM_RD_SRST_N) out_q <= 32'h0;
    else if (RAM_RD_EN) out_q <= lat_q;
  end
  assign RAM_RD = out_q;

  typedef struct { logic [31:0] data; int due; } ent_t;
  logic [31:0] model_q [$];
  ent_t        exp_q [$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          wr_idx = 0;
  int          rd_idx = 0;
  bit          exp_ovf = 1'b0;
  bit          exp_udf = 1'b0;
  bit          mon_en = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; entered and left 1 time unit after a rising edge.
  task automatic drive(input logic we, input logic [31:0] wd, input logic re, input logic fl);
    bit   push_e, pop_e;
    int   sz;
    ent_t ent;
    WE = we; WDATA = wd; RE = re; FLUSH = fl;
    #1;
    sz     = model_q.size();
    push_e = we && !fl && (sz < 512);
    pop_e  = re && !fl && (sz > 0);
    chk("ram_wen", RAM_WEN, push_e);
    chk("ram_ren", RAM_REN, pop_e);
    chk("ram_rd_srst_n", RAM_RD_SRST_N, !fl);
    if (push_e) begin
      chk("ram_waddr", RAM_WADDR, wr_idx % 512);
      chk("ram_wd", RAM_WD, wd);
    end
    if (pop_e) begin
      chk("ram_raddr", RAM_RADDR, rd_idx % 512);
      ent.data = model_q[0];
      ent.due  = cyc + 2;
    end
    @(posedge CLK);
    if (fl) begin
      model_q.delete();
      exp_q.delete();
      wr_idx = 0;
      rd_idx = 0;
    end else begin
      if (pop_e) begin
        void'(model_q.pop_front());
        exp_q.push_back(ent);
        rd_idx++;
      end
      if (push_e) begin
        model_q.push_back(wd);
        wr_idx++;
      end
    end
    exp_ovf = we && !fl && (sz == 512);
    exp_udf = re && !fl && (sz == 0);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_count"}, COUNT, 10'd0);
    chk({tag, "_empty"}, EMPTY, 1'b1);
    chk({tag, "_full"}, FULL, 1'b0);
    chk({tag, "_rvalid"}, RVALID, 1'b0);
    chk({tag, "_ovf"}, OVERFLOW, 1'b0);
    chk({tag, "_udf"}, UNDERFLOW, 1'b0);
    chk({tag, "_ram_wen"}, RAM_WEN, 1'b0);
    chk({tag, "_ram_ren"}, RAM_REN, 1'b0);
    chk({tag, "_srst_n"}, RAM_RD_SRST_N, 1'b1);
`ifdef FIFO_ALMOST_FLAGS_EN
    chk({tag, "_afull"}, AFULL, 1'b0);
    chk({tag, "_aempty"}, AEMPTY, 1'b1);
`endif
  endtask

  // Asynchronous reset in the middle of a cycle, with requests still asserted.
  task automatic reset_mid();
    WE = 1'b1; RE = 1'b1; FLUSH = 1'b0;
    ARST_N = 1'b0;
    #2;
    chk_reset_outputs("arst_mid");
    model_q.delete();
    exp_q.delete();
    wr_idx = 0; rd_idx = 0;
    exp_ovf = 1'b0; exp_udf = 1'b0;
    WE = 1'b0; RE = 1'b0;
    @(posedge CLK);
    #3 ARST_N = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever a read return is due and checks status.
  always @(negedge CLK) begin : mon
    bit due_now;
    int sz;
    if (mon_en) begin
      sz      = model_q.size();
      due_now = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("rvalid", RVALID, due_now);
      if (due_now) begin
        chk("rdata", RDATA, exp_q[0].data);
        void'(exp_q.pop_front());
      end
      chk("count", COUNT, sz);
      chk("full", FULL, sz == 512);
      chk("empty", EMPTY, sz == 0);
      chk("overflow", OVERFLOW, exp_ovf);
      chk("underflow", UNDERFLOW, exp_udf);
`ifdef FIFO_ALMOST_FLAGS_EN
      chk("afull", AFULL, sz >= 480);
      chk("aempty", AEMPTY, sz <= 32);
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ARST_N = 1'b0; FLUSH = 1'b0; WE = 1'b1; RE = 1'b1; WDATA = 32'h0;
    #12;
    chk_reset_outputs("reset");
    WE = 1'b0; RE = 1'b0;
    @(negedge CLK);
    ARST_N = 1'b1;
    mon_en = 1'b1;
    @(posedge CLK);
    #1;

    // Three pushes, three pops, data in order with two-cycle return.
    for (int i = 1; i <= 3; i++) drive(1'b1, 32'hA5A5_0000 + i, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b0, 1'b0);

    // Fill to 512, reject a 513th push, then push+pop while full.
    for (int i = 0; i < 512; i++) drive(1'b1, $urandom, 1'b0, 1'b0);
    drive(1'b1, 32'hDEAD_0513, 1'b0, 1'b0);
    drive(1'b1, 32'hDEAD_0514, 1'b1, 1'b0);
    for (int i = 0; i < 511; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b0, 1'b0);

    // Push+pop while empty: push wins, pop rejected.
    drive(1'b1, 32'h1234_5678, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b0, 1'b0);

    // Continuous streaming across the 511 -> 0 wrap.
    for (int i = 0; i < 1000; i++) drive(1'b1, $urandom, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush with reads in flight; same-cycle requests are dropped silently.
    for (int i = 0; i < 12; i++) drive(1'b1, $urandom, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b1, 32'hF1F1_F1F1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b0, 1'b0);

    // Randomised phases alternating fill-heavy and drain-heavy traffic.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 700; i++) begin
        logic we, re, fl;
        we = ($urandom_range(99) < ((p % 2 == 0) ? 95 : 15));
        re = ($urandom_range(99) < ((p % 2 == 0) ? 15 : 95));
        fl = ($urandom_range(999) == 0);
        if (p == 3 && i == 350) reset_mid();
        else drive(we, $urandom, re, fl);
      end
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b0, 1'b0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
